// File: rtl/dffram_host_ctrl_if.sv
// Host byte-request / response channel between a host and dffram_host_ctrl.
// The host drives the request fields and rsp_ready; the controller drives the rest.
interface dffram_host_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [4:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dffram_host_ctrl.sv
// Byte-wide host front end for a nibble-wide 2R1W RAM tile with two banks.
// Reads fetch both nibbles in one cycle; writes take two nibble cycles.
module dffram_host_ctrl (
    input  logic               clk,
    input  logic               rst,
    dffram_host_ctrl_if.slave  host,
    output logic [7:0]         ram_ui,
    output logic [7:0]         ram_uio,
    output logic               ram_rst_n,
    input  logic [7:0]         ram_uo
);

    typedef enum logic [2:0] {
        CFG_RST,
        CFG_REL,
        IDLE,
        RD,
        WLO,
        WHI,
        WEND,
        RSP
    } state_t;

    state_t     state_q, state_d;
    logic       cnt_q, cnt_d;
    logic       bank_q, bank_d;
    logic       pend_q, pend_d;
    logic       write_q, write_d;
    logic       err_q, err_d;
    logic [4:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CFG_RST;
            cnt_q   <= 1'b0;
            bank_q  <= 1'b0;
            pend_q  <= 1'b0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
            pend_q  <= pend_d;
            write_q <= write_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        pend_d  = pend_q;
        write_d = write_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            CFG_RST: begin
                if (cnt_q) begin
                    cnt_d   = 1'b0;
                    state_d = CFG_REL;
                end else begin
                    cnt_d = 1'b1;
                end
            end
            CFG_REL: begin
                pend_d = 1'b0;
                if (pend_q) state_d = write_q ? WLO : RD;
                else        state_d = IDLE;
            end
            IDLE: begin
                if (host.req_valid) begin
                    write_d = host.req_write;
                    addr_d  = host.req_addr;
                    wdata_d = host.req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    // Aliased region is rejected before the bank compare so it never reconfigures the tile
                    if (host.req_addr[4:3] == 2'b11) begin
                        err_d   = 1'b1;
                        state_d = RSP;
                    end else if (host.req_addr[4] != bank_q) begin
                        bank_d  = host.req_addr[4];
                        pend_d  = 1'b1;
                        cnt_d   = 1'b0;
                        state_d = CFG_RST;
                    end else begin
                        state_d = host.req_write ? WLO : RD;
                    end
                end
            end
            RD: begin
                rdata_d = ram_uo;
                state_d = RSP;
            end
            WLO:  state_d = WHI;
            WHI:  state_d = WEND;
            WEND: state_d = RSP;
            RSP: begin
                if (host.rsp_ready) state_d = IDLE;
            end
            default: state_d = CFG_RST;
        endcase
    end

    always_comb begin
        ram_rst_n      = 1'b1;
        ram_ui         = '0;
        ram_uio        = '0;
        host.req_ready = 1'b0;
        host.rsp_valid = 1'b0;

        case (state_q)
            CFG_RST: begin
                ram_rst_n = 1'b0;
                ram_uio   = {7'b0, bank_q};
            end
            IDLE: host.req_ready = 1'b1;
            RD: begin
                ram_ui  = {addr_q[3:0], 4'h0};
                ram_uio = {4'b0010, addr_q[3:0]};
            end
            WLO: begin
                ram_ui  = {addr_q[3:0], wdata_q[3:0]};
                ram_uio = {4'b1001, addr_q[3:0]};
            end
            WHI: begin
                ram_ui  = {addr_q[3:0], wdata_q[7:4]};
                ram_uio = {4'b1000, addr_q[3:0]};
            end
            // Address stays put for one cycle after w_en drops
            WEND: begin
                ram_ui  = {addr_q[3:0], wdata_q[7:4]};
                ram_uio = {4'b0000, addr_q[3:0]};
            end
            RSP: host.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign host.rsp_rdata = rdata_q;
    assign host.rsp_err   = err_q;

endmodule

// File: tb/tb_dffram_host_ctrl.sv
// Bench for dffram_host_ctrl: a per-cycle expected-pin schedule built from the
// request stream and a byte-addressed memory model, plus a nibble RAM tile model.
module tb_dffram_host_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ram_ui, ram_uio, ram_uo;
    logic       ram_rst_n;

    always #5 clk = ~clk;

    dffram_host_ctrl_if hif();

    dffram_host_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .host     (hif),
        .ram_ui   (ram_ui),
        .ram_uio  (ram_uio),
        .ram_rst_n(ram_rst_n),
        .ram_uo   (ram_uo)
    );

    // RAM tile: bank latched while held in reset; lohi selects nibble
    logic [7:0] tile_mem [2][16] = '{default: '0};
    logic       tile_bank = 1'b0;
    logic [7:0] byte_a, byte_b;

    always @(posedge clk) begin
        if (!ram_rst_n) tile_bank <= ram_uio[0];
        else if (ram_uio[7]) begin
            if (ram_uio[4]) tile_mem[tile_bank][ram_ui[7:4]][3:0] <= ram_ui[3:0];
            else            tile_mem[tile_bank][ram_ui[7:4]][7:4] <= ram_ui[3:0];
        end
    end

    always_comb begin
        byte_a = tile_mem[tile_bank][ram_ui[7:4]];
        byte_b = tile_mem[tile_bank][ram_uio[3:0]];
        ram_uo = {ram_uio[5] ? byte_b[7:4] : byte_b[3:0],
                  ram_uio[4] ? byte_a[7:4] : byte_a[3:0]};
    end

    typedef struct {
        string      name;
        logic       ready, valid, rst_n, err, care;
        logic [7:0] ui, ui_mask, uio, uio_mask, rdata;
    } exp_t;

    typedef struct {
        logic       ready, valid, rst_n, err;
        logic [7:0] ui, uio, rdata;
    } obs_t;

    exp_t       exp_q[$];
    obs_t       hist[$];
    int         checks = 0;
    int         errors = 0;
    logic       bank_m = 1'b0;
    logic [7:0] ref_mem [32] = '{default: '0};

    function automatic void chk(input string nm, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at t=%0t: got %02h, expected %02h", nm, $time, got, want);
        end
    endfunction

    function automatic exp_t mk(input string nm, input logic rdy, input logic vld, input logic rn,
                                input logic [7:0] u, input logic [7:0] um,
                                input logic [7:0] uo, input logic [7:0] uom);
        exp_t e;
        e.name = nm; e.ready = rdy; e.valid = vld; e.rst_n = rn;
        e.ui = u; e.ui_mask = um; e.uio = uo; e.uio_mask = uom;
        e.care = 1'b0; e.err = 1'b0; e.rdata = 8'h00;
        return e;
    endfunction

    function automatic exp_t rsp_e(input logic [7:0] rd, input logic er);
        exp_t e;
        e = mk("rsp", 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h80);
        e.care = 1'b1; e.rdata = rd; e.err = er;
        return e;
    endfunction

    function automatic exp_t reset_e();
        exp_t e;
        e = mk("in_reset", 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF);
        e.care = 1'b1;
        return e;
    endfunction

    function automatic void push_cfg(input logic b);
        exp_q.push_back(mk("cfg_rst", 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, {7'b0, b}, 8'hFF));
        exp_q.push_back(mk("cfg_rst", 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, {7'b0, b}, 8'hFF));
        exp_q.push_back(mk("cfg_rel", 1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF));
    endfunction

    // Compare process: one scheduled expectation per cycle, sampled mid-cycle
    initial begin
        exp_t e;
        obs_t o;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o.ready = hif.req_ready; o.valid = hif.rsp_valid; o.rst_n = ram_rst_n;
                o.err = hif.rsp_err; o.ui = ram_ui; o.uio = ram_uio; o.rdata = hif.rsp_rdata;
                hist.push_back(o);
                chk({e.name, " req_ready"}, {7'b0, o.ready}, {7'b0, e.ready});
                chk({e.name, " rsp_valid"}, {7'b0, o.valid}, {7'b0, e.valid});
                chk({e.name, " ram_rst_n"}, {7'b0, o.rst_n}, {7'b0, e.rst_n});
                chk({e.name, " ram_ui"}, o.ui & e.ui_mask, e.ui & e.ui_mask);
                chk({e.name, " ram_uio"}, o.uio & e.uio_mask, e.uio & e.uio_mask);
                if (e.care) begin
                    chk({e.name, " rsp_rdata"}, o.rdata, e.rdata);
                    chk({e.name, " rsp_err"}, {7'b0, o.err}, {7'b0, e.err});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        hif.req_valid = 1'b0;
        hif.rsp_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(reset_e());
            step();
        end
        rst = 1'b0;
        bank_m = 1'b0;
        push_cfg(1'b0);
        repeat (3) step();
    endtask

    task automatic txn(input logic wr, input logic [4:0] a, input logic [7:0] d,
                       input int hold, input logic abort);
        int         n;
        logic       alias_hit;
        logic [7:0] rd;
        alias_hit = (a[4:3] == 2'b11);
        hif.req_valid = 1'b1;
        hif.req_write = wr;
        hif.req_addr  = a;
        hif.req_wdata = d;
        exp_q.push_back(mk("idle", 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h80));
        n = 1;
        if (!alias_hit && a[4] != bank_m) begin
            bank_m = a[4];
            push_cfg(bank_m);
            n += 3;
        end
        if (!alias_hit) begin
            if (wr) begin
                exp_q.push_back(mk("wlo", 1'b0, 1'b0, 1'b1, {a[3:0], d[3:0]}, 8'hFF, {4'b1001, a[3:0]}, 8'hFF));
                n++;
                if (!abort) begin
                    exp_q.push_back(mk("whi", 1'b0, 1'b0, 1'b1, {a[3:0], d[7:4]}, 8'hFF, {4'b1000, a[3:0]}, 8'hFF));
                    exp_q.push_back(mk("wend", 1'b0, 1'b0, 1'b1, {a[3:0], 4'h0}, 8'hF0, {4'b0000, a[3:0]}, 8'hFF));
                    n += 2;
                end
            end else begin
                exp_q.push_back(mk("rd", 1'b0, 1'b0, 1'b1, {a[3:0], 4'h0}, 8'hFF, {4'b0010, a[3:0]}, 8'hFF));
                n++;
            end
        end
        rd = (alias_hit || wr) ? 8'h00 : ref_mem[a];
        if (!abort) begin
            for (int i = 0; i <= hold; i++) exp_q.push_back(rsp_e(rd, alias_hit));
            n += hold + 1;
        end
        for (int i = 0; i < n; i++) begin
            hif.rsp_ready = !abort && (i == n - 1);
            step();
            hif.req_valid = 1'b0;
        end
        hif.rsp_ready = 1'b0;
        // An abort during WHI leaves only the low nibble committed
        if (wr && !alias_hit) ref_mem[a] = abort ? {ref_mem[a][7:4], d[3:0]} : d;
    endtask

    initial begin
        int s;
        hif.req_valid = 1'b0;
        hif.req_write = 1'b0;
        hif.req_addr  = '0;
        hif.req_wdata = '0;
        hif.rsp_ready = 1'b0;
        step();

        s = hist.size();
        do_reset(3);
        chk("rst rst_n",      {7'b0, hist[s].rst_n},   8'h00);
        chk("rst rsp_rdata",  hist[s].rdata,            8'h00);
        chk("cfg_rst0 uio",   hist[s+3].uio,            8'h00);
        chk("cfg_rst1 rst_n", {7'b0, hist[s+4].rst_n}, 8'h00);
        chk("cfg_rel rst_n",  {7'b0, hist[s+5].rst_n}, 8'h01);

        s = hist.size();
        txn(1'b1, 5'h05, 8'hA7, 0, 1'b0);
        chk("w05 ready",   {7'b0, hist[s].ready},   8'h01);
        chk("w05 wlo ui",  hist[s+1].ui,             8'h57);
        chk("w05 wlo uio", hist[s+1].uio,            8'h95);
        chk("w05 whi ui",  hist[s+2].ui,             8'h5A);
        chk("w05 whi uio", hist[s+2].uio,            8'h85);
        chk("w05 wend uio", hist[s+3].uio,           8'h05);
        chk("w05 valid",   {7'b0, hist[s+4].valid}, 8'h01);
        chk("w05 err",     {7'b0, hist[s+4].err},   8'h00);

        s = hist.size();
        txn(1'b0, 5'h05, 8'h00, 0, 1'b0);
        chk("r05 rd ui",  hist[s+1].ui,    8'h50);
        chk("r05 rd uio", hist[s+1].uio,   8'h25);
        chk("r05 rdata",  hist[s+2].rdata, 8'hA7);

        s = hist.size();
        txn(1'b0, 5'h13, 8'h00, 0, 1'b0);
        chk("r13 cfg0 uio",   hist[s+1].uio,            8'h01);
        chk("r13 cfg1 uio",   hist[s+2].uio,            8'h01);
        chk("r13 rel uio",    hist[s+3].uio,            8'h00);
        chk("r13 rd uio",     hist[s+4].uio,            8'h23);
        chk("r13 rd valid",   {7'b0, hist[s+4].valid}, 8'h00);
        chk("r13 rsp valid",  {7'b0, hist[s+5].valid}, 8'h01);

        txn(1'b1, 5'h13, 8'h3C, 0, 1'b0);
        txn(1'b1, 5'h10, 8'h11, 1, 1'b0);
        txn(1'b1, 5'h17, 8'hFE, 0, 1'b0);
        txn(1'b0, 5'h05, 8'h00, 0, 1'b0);
        txn(1'b1, 5'h00, 8'h5A, 0, 1'b0);
        txn(1'b1, 5'h0F, 8'hC3, 2, 1'b0);
        txn(1'b0, 5'h0F, 8'h00, 0, 1'b0);
        txn(1'b0, 5'h00, 8'h00, 0, 1'b0);
        txn(1'b0, 5'h13, 8'h00, 0, 1'b0);

        s = hist.size();
        txn(1'b1, 5'h1C, 8'h77, 5, 1'b0);
        chk("a1c err",      {7'b0, hist[s+1].err},   8'h01);
        chk("a1c rdata",    hist[s+1].rdata,          8'h00);
        chk("a1c uio",      hist[s+1].uio,            8'h00);
        chk("a1c held valid", {7'b0, hist[s+6].valid}, 8'h01);

        s = hist.size();
        txn(1'b0, 5'h13, 8'h00, 0, 1'b0);
        chk("r13 same bank uio", hist[s+1].uio,   8'h23);
        chk("r13 rdata",         hist[s+2].rdata, 8'h3C);

        txn(1'b0, 5'h18, 8'h00, 0, 1'b0);
        txn(1'b0, 5'h1F, 8'h00, 1, 1'b0);
        txn(1'b0, 5'h17, 8'h00, 0, 1'b0);
        txn(1'b0, 5'h10, 8'h00, 0, 1'b0);

        s = hist.size();
        txn(1'b1, 5'h15, 8'h96, 0, 1'b1);
        do_reset(2);
        chk("abort rst_n", {7'b0, hist[s+2].rst_n}, 8'h00);
        chk("abort uio",   hist[s+2].uio,            8'h00);
        chk("abort valid", {7'b0, hist[s+2].valid}, 8'h00);

        txn(1'b0, 5'h05, 8'h00, 0, 1'b0);
        txn(1'b0, 5'h15, 8'h00, 0, 1'b0);

        exp_q.push_back(mk("idle", 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h80));
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
